// File: rtl/lsu_load_unit.sv
//------------------------------------------------------------------------------
// Module  : lsu_load_unit
// Brief   : Single-outstanding load unit: aligned 64-bit read, extract, extend.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lsu_load_unit #(
  parameter int ADDR_W      = 64,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  output logic              mem_arvalid,
  input  logic              mem_arready,
  output logic [ADDR_W-1:0] mem_araddr,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  input  logic [63:0]       mem_rdata,
  input  logic              mem_rerr,
  output logic              load_valid,
  input  logic              load_ready,
  output logic [63:0]       load_data,
  output logic              load_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [2:0]          r_off;
  logic [2:0]          r_funct3;
  logic [ADDR_W-1:0]   r_araddr;
  logic                r_arvalid;
  logic                r_rready;
  logic                r_load_valid;
  logic [63:0]         r_load_data;
  logic                r_load_err;
  logic                w_misaligned;
  logic                w_req_err;
  logic [63:0]         w_shifted;
  logic [63:0]         w_ext;

  always_comb begin
    w_misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b01:   w_misaligned = req_addr[0];
      2'b10:   w_misaligned = |req_addr[1:0];
      2'b11:   w_misaligned = |req_addr[2:0];
      default: w_misaligned = 1'b0;
    endcase
    w_req_err = (req_funct3 == 3'b111) || (CHECK_ALIGN && w_misaligned);
  end

  // Logical shift zero-fills bytes past bit 63, so a truncated field extends
  // from a zero sign bit when the access runs off the doubleword.
  always_comb begin
    w_shifted = mem_rdata >> {r_off, 3'b000};
    w_ext     = 64'd0;
    case (r_funct3)
      3'b000:  w_ext = {{56{w_shifted[7]}},  w_shifted[7:0]};
      3'b001:  w_ext = {{48{w_shifted[15]}}, w_shifted[15:0]};
      3'b010:  w_ext = {{32{w_shifted[31]}}, w_shifted[31:0]};
      3'b011:  w_ext = mem_rdata;
      3'b100:  w_ext = {56'd0, w_shifted[7:0]};
      3'b101:  w_ext = {48'd0, w_shifted[15:0]};
      3'b110:  w_ext = {32'd0, w_shifted[31:0]};
      default: w_ext = 64'd0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid)   w_state_next = w_req_err ? S_RESP : S_REQ;
      S_REQ:  if (mem_arready) w_state_next = S_WAIT;
      S_WAIT: if (mem_rvalid)  w_state_next = S_RESP;
      S_RESP: if (load_ready)  w_state_next = S_IDLE;
      default:                 w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_off        <= 3'd0;
      r_funct3     <= 3'd0;
      r_araddr     <= '0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_load_valid <= 1'b0;
      r_load_data  <= 64'd0;
      r_load_err   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_arvalid    <= (w_state_next == S_REQ);
      r_rready     <= (w_state_next == S_WAIT);
      r_load_valid <= (w_state_next == S_RESP);
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_off    <= req_addr[2:0];
            r_funct3 <= req_funct3;
            r_araddr <= {req_addr[ADDR_W-1:3], 3'b000};
            if (w_req_err) begin
              r_load_err  <= 1'b1;
              r_load_data <= 64'd0;
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            r_load_err  <= mem_rerr;
            r_load_data <= mem_rerr ? 64'd0 : w_ext;
          end
        end
        S_RESP: begin
          if (load_ready) begin
            r_load_err  <= 1'b0;
            r_load_data <= 64'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign mem_arvalid = r_arvalid;
  assign mem_araddr  = r_araddr;
  assign mem_rready  = r_rready;
  assign load_valid  = r_load_valid;
  assign load_data   = r_load_data;
  assign load_err    = r_load_err;

endmodule

`default_nettype wire

// File: tb/tb_lsu_load_unit.sv
//------------------------------------------------------------------------------
// Module  : tb_lsu_load_unit
// Brief   : Scoreboard bench for lsu_load_unit (CHECK_ALIGN=1).
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_lsu_load_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [2:0]  req_funct3;
  logic        mem_arvalid;
  logic        mem_arready;
  logic [63:0] mem_araddr;
  logic        mem_rvalid;
  logic        mem_rready;
  logic [63:0] mem_rdata;
  logic        mem_rerr;
  logic        load_valid;
  logic        load_ready;
  logic [63:0] load_data;
  logic        load_err;

  always #5 clk = ~clk;

  lsu_load_unit #(.ADDR_W(64), .CHECK_ALIGN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_funct3(req_funct3),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
    .mem_rdata(mem_rdata), .mem_rerr(mem_rerr),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_err(load_err)
  );

  typedef struct packed {
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   ar_hs    = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Result handshakes are scored here against the queued expectations.
  always @(negedge clk) begin
    exp_t e;
    if (mem_arvalid && mem_arready) ar_hs++;
    if (load_valid && load_ready) begin
      check_eq("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("load_data", load_data, e.data);
        check_eq("load_err", {63'd0, load_err}, {63'd0, e.err});
      end
    end
  end

  task automatic run_load(input logic [63:0] addr, input logic [2:0] f3,
                          input logic [63:0] rdata, input bit rerr,
                          input int ar_delay, input int ld_delay, input bit exp_mem,
                          input logic [63:0] exp_data, input bit exp_err);
    int hs0;
    logic [63:0] aligned;
    aligned = {addr[63:3], 3'b000};
    sb.push_back(exp_t'{data: exp_data, err: exp_err});
    check_eq("req_ready_idle", {63'd0, req_ready}, 64'd1);
    hs0        = ar_hs;
    req_valid  = 1'b1;
    req_addr   = addr;
    req_funct3 = f3;
    step();
    req_valid  = 1'b0;
    check_eq("req_ready_busy", {63'd0, req_ready}, 64'd0);
    if (exp_mem) begin
      for (int i = 0; i < ar_delay; i++) begin
        check_eq("arvalid_hold", {63'd0, mem_arvalid}, 64'd1);
        check_eq("araddr_hold", mem_araddr, aligned);
        step();
      end
      check_eq("arvalid", {63'd0, mem_arvalid}, 64'd1);
      check_eq("araddr", mem_araddr, aligned);
      mem_arready = 1'b1;
      step();
      mem_arready = 1'b0;
      check_eq("arvalid_drop", {63'd0, mem_arvalid}, 64'd0);
      check_eq("rready", {63'd0, mem_rready}, 64'd1);
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      mem_rerr   = rerr;
      step();
      mem_rvalid = 1'b0;
      mem_rerr   = 1'b0;
    end
    check_eq("ar_handshakes", 64'(ar_hs - hs0), {63'd0, exp_mem});
    check_eq("load_valid", {63'd0, load_valid}, 64'd1);
    for (int i = 0; i < ld_delay; i++) begin
      check_eq("hold_data", load_data, exp_data);
      check_eq("hold_err", {63'd0, load_err}, {63'd0, exp_err});
      check_eq("hold_req_ready", {63'd0, req_ready}, 64'd0);
      check_eq("hold_valid", {63'd0, load_valid}, 64'd1);
      step();
    end
    load_ready = 1'b1;
    step();
    load_ready = 1'b0;
    check_eq("load_valid_drop", {63'd0, load_valid}, 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
    check_eq({tag, "_arvalid"}, {63'd0, mem_arvalid}, 64'd0);
    check_eq({tag, "_rready"}, {63'd0, mem_rready}, 64'd0);
    check_eq({tag, "_load_valid"}, {63'd0, load_valid}, 64'd0);
    check_eq({tag, "_load_err"}, {63'd0, load_err}, 64'd0);
    check_eq({tag, "_load_data"}, load_data, 64'd0);
    check_eq({tag, "_araddr"}, mem_araddr, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_addr    = 64'd0;
    req_funct3  = 3'd0;
    mem_arready = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 64'd0;
    mem_rerr    = 1'b0;
    load_ready  = 1'b0;
    #1;
    check_reset_outputs("rst");
    step();
    step();
    rst_n = 1'b1;
    step();
    check_reset_outputs("post_rst");

    // Extraction and extension
    run_load(64'h1003, 3'b000, 64'h0000_0000_8000_0000, 1'b0, 0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    run_load(64'h2004, 3'b100, 64'h8765_4321_0000_0000, 1'b0, 0, 0, 1'b1, 64'h0000_0000_0000_0021, 1'b0);
    run_load(64'h2004, 3'b101, 64'h8765_4321_0000_0000, 1'b0, 0, 0, 1'b1, 64'h0000_0000_0000_4321, 1'b0);
    run_load(64'h2004, 3'b110, 64'h8765_4321_0000_0000, 1'b0, 0, 0, 1'b1, 64'h0000_0000_8765_4321, 1'b0);
    run_load(64'h2004, 3'b010, 64'h8765_4321_0000_0000, 1'b0, 0, 0, 1'b1, 64'hFFFF_FFFF_8765_4321, 1'b0);

    // Errors detected on accept, no bus access
    run_load(64'h3002, 3'b010, 64'd0, 1'b0, 0, 1, 1'b0, 64'd0, 1'b1);
    run_load(64'h3000, 3'b111, 64'd0, 1'b0, 0, 0, 1'b0, 64'd0, 1'b1);
    run_load(64'h1001, 3'b101, 64'd0, 1'b0, 0, 0, 1'b0, 64'd0, 1'b1);
    run_load(64'h1004, 3'b011, 64'd0, 1'b0, 0, 0, 1'b0, 64'd0, 1'b1);

    // Stalled address channel, bus error, stalled write-back
    run_load(64'h4000, 3'b011, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 5, 4, 1'b1, 64'd0, 1'b1);

    // Back-to-back: second request in the IDLE cycle right after the handshake
    run_load(64'h5000, 3'b011, 64'h0123_4567_89AB_CDEF, 1'b0, 0, 0, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0);
    run_load(64'h5006, 3'b001, 64'hFEDC_0000_0000_0000, 1'b0, 0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FEDC, 1'b0);

    // Asynchronous reset while waiting for read data
    req_valid  = 1'b1;
    req_addr   = 64'h6000;
    req_funct3 = 3'b011;
    step();
    req_valid   = 1'b0;
    mem_arready = 1'b1;
    step();
    mem_arready = 1'b0;
    check_eq("abort_rready", {63'd0, mem_rready}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    step();
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    check_eq("stray_rready", {63'd0, mem_rready}, 64'd0);
    step();
    mem_rvalid = 1'b0;
    check_eq("stray_load_valid", {63'd0, load_valid}, 64'd0);
    check_eq("stray_req_ready", {63'd0, req_ready}, 64'd1);
    run_load(64'h7002, 3'b101, 64'h0000_0000_BEEF_0000, 1'b0, 0, 0, 1'b1, 64'h0000_0000_0000_BEEF, 1'b0);

    step();
    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
